// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: data width, strobe encodings
// and word-alignment helpers.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        IORD_PC  = 1'b0,
        IORD_ALU = 1'b1
    } iord_e;

    typedef enum logic {
        PCSRC_ALU    = 1'b0,
        PCSRC_ALUOUT = 1'b1
    } pcsrc_e;

    // Byte-offset bits that must be zero for a word access.
    localparam logic [XLEN-1:0] WORD_ALIGN_MASK = 32'h0000_0003;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |(addr & WORD_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/unified_mem.sv
// Unified instruction/data memory: MEM_WORDS x 32, combinational read,
// single synchronous write port. Contents are never reset.
module unified_mem #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_fetch_unit.sv
// PC, IR, MDR and unified memory for the multicycle controller; purely
// strobe-driven, with sticky misalignment and protocol error flags.
module mem_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWriteCondition,
    input  logic              PCWrite,
    input  logic              IorD,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic              PCSource,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       wdata,
    input  logic              zero,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic [31:0]       mdr,
    output logic              misalign_err,
    output logic              protocol_err
);

    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_ir;
    logic [XLEN-1:0]   r_mdr;
    logic              r_misalign_err;
    logic              r_protocol_err;

    logic [XLEN-1:0]   w_addr;
    logic [ADDR_W-1:0] w_idx;
    logic              w_misaligned;
    logic              w_mem_access;
    logic [XLEN-1:0]   w_rdata;
    logic              w_pc_en;
    logic [XLEN-1:0]   w_pc_next;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [XLEN-1:0]   w_mem_wdata;
    logic              w_set_misalign;
    logic              w_set_protocol;
    logic              w_unused_addr_hi;

    assign w_addr       = (IorD == IORD_ALU) ? alu_out : r_pc;
    assign w_idx        = w_addr[ADDR_W+1:2];
    assign w_misaligned = is_misaligned(w_addr);
    // Address bits above the word index simply wrap around the array.
    assign w_unused_addr_hi = ^w_addr[XLEN-1:ADDR_W+2];

    assign w_mem_access   = MemRead | MemWrite | IRWrite;
    assign w_set_misalign = w_mem_access & w_misaligned;
    assign w_set_protocol = (IRWrite & ~MemRead)
                          | (MemRead & MemWrite)
                          | (prog_we & MemWrite);

    assign w_pc_en   = PCWrite | (PCWriteCondition & zero);
    assign w_pc_next = (PCSource == PCSRC_ALUOUT) ? alu_out : alu_result;

    // Boot port wins the single write port; misaligned controller stores drop.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = w_idx;
        w_mem_wdata = wdata;
        if (prog_we) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = prog_addr;
            w_mem_wdata = prog_data;
        end else if (MemWrite && !w_misaligned) begin
            w_mem_we    = 1'b1;
        end
    end

    unified_mem #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    // w_rdata is the pre-edge array value, so same-edge writes read old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_ir           <= '0;
            r_mdr          <= '0;
            r_misalign_err <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
            if (MemRead) begin
                r_mdr <= w_rdata;
            end
            if (MemRead && IRWrite) begin
                r_ir <= w_rdata;
            end
            if (w_set_misalign) begin
                r_misalign_err <= 1'b1;
            end
            if (w_set_protocol) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign pc           = r_pc;
    assign instr        = r_ir;
    assign mdr          = r_mdr;
    assign misalign_err = r_misalign_err;
    assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Directed and randomized checks of mem_fetch_unit against a word-array
// reference model of the strobe rules.
module tb_mem_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCWriteCondition, PCWrite, IorD, MemRead, MemWrite, IRWrite, PCSource, zero;
    logic [31:0] alu_result, alu_out, wdata, prog_data;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] pc, instr, mdr;
    logic        misalign_err, protocol_err;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_ir, m_mdr;
    logic        m_mis, m_prot;

    mem_fetch_unit #(
        .MEM_WORDS (256),
        .ADDR_W    (8),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .PCWriteCondition (PCWriteCondition),
        .PCWrite          (PCWrite),
        .IorD             (IorD),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .IRWrite          (IRWrite),
        .PCSource         (PCSource),
        .alu_result       (alu_result),
        .alu_out          (alu_out),
        .wdata            (wdata),
        .zero             (zero),
        .prog_we          (prog_we),
        .prog_addr        (prog_addr),
        .prog_data        (prog_data),
        .pc               (pc),
        .instr            (instr),
        .mdr              (mdr),
        .misalign_err     (misalign_err),
        .protocol_err     (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".instr"}, instr, m_ir);
        chk({tag, ".mdr"}, mdr, m_mdr);
        chk({tag, ".misalign"}, {31'd0, misalign_err}, {31'd0, m_mis});
        chk({tag, ".protocol"}, {31'd0, protocol_err}, {31'd0, m_prot});
    endtask

    task automatic idle();
        PCWriteCondition = 0; PCWrite = 0; IorD = 0; MemRead = 0; MemWrite = 0;
        IRWrite = 0; PCSource = 0; zero = 0; prog_we = 0; prog_addr = '0;
        prog_data = '0; alu_result = '0; alu_out = '0; wdata = '0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_mis = 0; m_prot = 0;
    endtask

    // Reference behaviour for one rising edge, from the current inputs.
    task automatic model_edge();
        logic [31:0] a, rd;
        int unsigned idx;
        logic        mis;
        a   = IorD ? alu_out : m_pc;
        idx = (a / 4) % 256;
        mis = (a % 4) != 0;
        rd  = m_mem[idx];
        if ((MemRead || MemWrite || IRWrite) && mis) m_mis = 1;
        if ((IRWrite && !MemRead) || (MemRead && MemWrite) || (prog_we && MemWrite)) m_prot = 1;
        if (MemRead) m_mdr = rd;
        if (MemRead && IRWrite) m_ir = rd;
        if (prog_we) m_mem[prog_addr] = prog_data;
        else if (MemWrite && !mis) m_mem[idx] = wdata;
        if (PCWrite || (PCWriteCondition && zero)) m_pc = PCSource ? alu_out : alu_result;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
        idle();
    endtask

    task automatic async_reset(input string tag);
        rst = 1;
        #1;
        model_reset();
        chk({tag, ".pc"}, pc, 32'h0);
        chk({tag, ".instr"}, instr, 32'h0);
        chk({tag, ".mdr"}, mdr, 32'h0);
        chk({tag, ".flags"}, {30'd0, misalign_err, protocol_err}, 32'h0);
        rst = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom_range(0, 63) * 4;
        if ($urandom_range(0, 9) == 0) a = a | $urandom_range(1, 3);
        if ($urandom_range(0, 4) == 0) a = a | ($urandom & 32'hFFFF_FC00);
        return a;
    endfunction

    initial begin
        idle();
        model_reset();
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;

        // Boot-load every word so the model and the array agree everywhere.
        for (int i = 0; i < 256; i++) begin
            prog_we   = 1;
            prog_addr = i[7:0];
            prog_data = (i == 0) ? 32'h00C1_2283 : $urandom;
            cycle("boot");
        end
        async_reset("reset");

        // Fetch with same-edge PC increment.
        MemRead = 1; IRWrite = 1; IorD = 0; PCWrite = 1; PCSource = 0; alu_result = 32'd4;
        cycle("fetch");
        chk("fetch.instr_const", instr, 32'h00C1_2283);
        chk("fetch.mdr_const", mdr, 32'h00C1_2283);
        chk("fetch.pc_const", pc, 32'd4);

        // Store then load.
        IorD = 1; alu_out = 32'h10; wdata = 32'hDEAD_BEEF; MemWrite = 1;
        cycle("store");
        IorD = 1; alu_out = 32'h10; MemRead = 1;
        cycle("load");
        chk("load.mdr_const", mdr, 32'hDEAD_BEEF);
        chk("load.protocol_const", {31'd0, protocol_err}, 32'd0);

        // Conditional branch, not taken then taken.
        PCWrite = 1; alu_result = 32'd8;
        cycle("setpc8");
        PCWriteCondition = 1; zero = 0; PCSource = 1; alu_out = 32'hFFFF_FFF8;
        cycle("br_nt");
        chk("br_nt.pc_const", pc, 32'd8);
        PCWriteCondition = 1; zero = 1; PCSource = 1; alu_out = 32'hFFFF_FFF8;
        cycle("br_t");
        chk("br_t.pc_const", pc, 32'hFFFF_FFF8);

        // Misaligned store is dropped and flagged.
        MemWrite = 1; IorD = 1; alu_out = 32'h13; wdata = 32'h0BAD_0BAD;
        cycle("mis_st");
        chk("mis_st.flag_const", {31'd0, misalign_err}, 32'd1);
        IorD = 1; alu_out = 32'h10; MemRead = 1;
        cycle("mis_chk");
        chk("mis_chk.mem4_const", mdr, 32'hDEAD_BEEF);

        // Simultaneous read/write: read-before-write plus protocol error.
        MemRead = 1; MemWrite = 1; IorD = 1; alu_out = 32'h10; wdata = 32'h1234_5678;
        cycle("rw");
        chk("rw.mdr_const", mdr, 32'hDEAD_BEEF);
        chk("rw.protocol_const", {31'd0, protocol_err}, 32'd1);
        IorD = 1; alu_out = 32'h10; MemRead = 1;
        cycle("rw_chk");
        chk("rw_chk.mem4_const", mdr, 32'h1234_5678);
        IRWrite = 1; MemRead = 0;
        cycle("irw_noread");
        chk("irw_noread.instr_const", instr, 32'h00C1_2283);
        chk("irw_noread.sticky_mis", {31'd0, misalign_err}, 32'd1);

        // Reset between edges, memory retained.
        PCWrite = 1; alu_result = 32'd4;
        cycle("setpc4");
        async_reset("midrst");
        MemRead = 1; IRWrite = 1; IorD = 0;
        cycle("refetch");
        chk("refetch.instr_const", instr, 32'h00C1_2283);

        // Randomized strobes against the reference model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rnd_rst");
            end
            PCWriteCondition = $urandom_range(0, 3) == 0;
            PCWrite          = $urandom_range(0, 3) == 0;
            IorD             = $urandom_range(0, 1);
            MemRead          = $urandom_range(0, 1);
            MemWrite         = $urandom_range(0, 3) == 0;
            IRWrite          = $urandom_range(0, 2) == 0;
            PCSource         = $urandom_range(0, 1);
            zero             = $urandom_range(0, 1);
            alu_result       = rand_addr();
            alu_out          = rand_addr();
            wdata            = $urandom;
            prog_we          = $urandom_range(0, 9) == 0;
            prog_addr        = 8'($urandom_range(0, 255));
            prog_data        = $urandom;
            cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_fetch_unit.md
Name: mem_fetch_unit

Overview:
Responder side of the multicycle controller's control interface. It holds the PC, a unified word-addressed instruction/data memory, the instruction register (IR) and the memory data register (MDR). It acts on the controller's PCWriteCondition, PCWrite, IorD, MemRead, MemWrite, IRWrite and PCSource strobes, and drives instr back into the controller. It sits between the controller and the ALU/register-file datapath.

Parameters:
MEM_WORDS, 256, memory depth in 32-bit words; must be a power of 2.
ADDR_W, 8, word-index width; equals log2(MEM_WORDS).
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
PCWriteCondition  in  1  PC write if zero=1
PCWrite  in  1  unconditional PC write
IorD  in  1  address select: 0 = pc, 1 = alu_out
MemRead  in  1  memory read strobe
MemWrite  in  1  memory write strobe
IRWrite  in  1  load IR from memory
PCSource  in  1  PC source: 0 = alu_result, 1 = alu_out
alu_result  in  32  combinational ALU output
alu_out  in  32  registered ALUOut value
wdata  in  32  store data (B register)
zero  in  1  ALU zero flag
prog_we  in  1  testbench/boot memory write enable
prog_addr  in  ADDR_W  boot write word index
prog_data  in  32  boot write data
pc  out  32  program counter
instr  out  32  instruction register, to controller
mdr  out  32  memory data register
misalign_err  out  1  sticky misaligned access flag
protocol_err  out  1  sticky illegal strobe combination flag

Behaviour:
- Reset (async, immediate): pc=RESET_PC, instr=0, mdr=0, misalign_err=0, protocol_err=0. Memory contents are not reset and are retained across rst.
- Address: addr = IorD ? alu_out : pc. Word index = addr[ADDR_W+1:2]. Upper bits are ignored (wrap modulo MEM_WORDS).
- Misaligned: addr[1:0]!=0 during MemRead, MemWrite or IRWrite sets misalign_err at the edge.
  - Misaligned writes are suppressed.
  - Misaligned reads return the aligned word.
- Memory read: combinational array read. All register loads happen at the rising edge, so data is visible one cycle after the strobe.
- MDR: loads mem[index] at each edge with MemRead=1; otherwise holds.
- IR: loads mem[index] at an edge with IRWrite=1 and MemRead=1.
  - IRWrite=1 with MemRead=0: IR holds and protocol_err is set.
- Memory write: at an edge with MemWrite=1 and aligned addr, mem[index] <= wdata.
- MemRead and MemWrite together: protocol_err is set, the write is performed, and MDR/IR capture the pre-write data (read-before-write).
- prog_we: mem[prog_addr] <= prog_data, with priority over MemWrite.
  - prog_we and MemWrite in the same cycle: controller write dropped, protocol_err set.
- PC update: pc_en = PCWrite | (PCWriteCondition & zero). When pc_en=1, pc <= PCSource ? alu_out : alu_result, with the full 32 bits captured.
  - A misaligned PC is flagged only when it is next used for fetch.
- PCWrite and PCWriteCondition both high: PCWrite dominates (pc written); no error.
- Same-edge fetch and PC write: IR captures mem[old pc] and the PC then updates. This ordering is normal in the fetch state.
- Sticky flags clear only on rst.
- No internal FSM: the unit is purely strobe-driven, with registered state (pc, IR, MDR, flags, memory).

Decomposition:
- Shared package, cpu_pkg:
  - XLEN=32.
  - Encodings IORD_PC=0, IORD_ALU=1.
  - Encodings PCSRC_ALU=0, PCSRC_ALUOUT=1.
  - Word-alignment mask constant.
- Sub-module unified_mem:
  - MEM_WORDS x 32 array, combinational read, synchronous write.
  - Two write ports arbitrated prog>ctrl inside mem_fetch_unit.
  - Instantiated once.
- PC/IR/MDR registers and error logic live in mem_fetch_unit.

Test Plan:
- Fetch: boot-load mem[0]=32'h00C12283; rst pulse; MemRead=1, IRWrite=1, IorD=0 for one edge -> instr=32'h00C12283 and mdr=32'h00C12283 after the edge. Same edge PCWrite=1, PCSource=0, alu_result=4 -> pc=4.
- Store/load: IorD=1, alu_out=32'h10, wdata=32'hDEADBEEF, MemWrite=1 -> next cycle MemRead=1, same address -> mdr=32'hDEADBEEF, protocol_err=0.
- Branch:
  - pc=8, PCWriteCondition=1, zero=0, PCSource=1, alu_out=32'hFFFFFFF8 -> pc stays 8.
  - Repeat with zero=1 -> pc=32'hFFFFFFF8.
- Misaligned: MemWrite=1, IorD=1, alu_out=32'h13 -> mem[4] unchanged, misalign_err=1 and held until rst.
- Protocol: MemRead=MemWrite=1 at alu_out=32'h10 with old data 32'hDEADBEEF, wdata=32'h12345678 -> mdr=32'hDEADBEEF, mem[4]=32'h12345678, protocol_err=1. Then IRWrite=1, MemRead=0 -> instr unchanged.
- Reset mid-operation: assert rst between edges while pc=4 -> pc=0, instr=0, mdr=0 and flags=0 immediately without a clock edge. Then fetch -> mem[0] still 32'h00C12283.
